// File: rtl/us_timming_rr_scheduler.sv
// us_timming_rr_scheduler: round-robin burst reader draining timing caches into one framed stream
module us_timming_rr_scheduler #(
  parameter int TOTAL_NUM = 104,
  parameter int DATA_W    = 128,
  parameter int CNT_W     = 12,
  parameter int IDX_W     = 7,
  parameter int BURST_MAX = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [TOTAL_NUM-1:0]          cache_empty_i,
  input  logic [TOTAL_NUM*CNT_W-1:0]    cache_count_i,
  input  logic [TOTAL_NUM*DATA_W-1:0]   cache_dout_i,
  output logic [TOTAL_NUM-1:0]          cache_rd_en_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic                          m_sop_o,
  output logic                          m_eop_o,
  output logic [IDX_W-1:0]              m_chan_o,
  output logic                          busy_o
);
  localparam int BL_W = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} state_t;
  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_ptr, r_idx, w_win;
  logic [IDX_W:0]    w_k;
  logic [BL_W-1:0]   r_left, w_len;
  logic [CNT_W-1:0]  w_cnt;
  logic              r_first, w_found, w_pop;
  logic              r_valid, r_sop, r_eop;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_chan;
  // state register
  always_ff @(posedge sys_clk_i) r_state <= rst_i ? S_IDLE : w_next;
  // next state: idle until work, one arbitration cycle, then drain the granted burst
  always_comb begin
    w_next = (r_state == S_IDLE) ? ((enable_i && !(&cache_empty_i)) ? S_ARB : S_IDLE)
           : (r_state == S_ARB)  ? (w_found ? S_XFER : S_IDLE)
           : (r_left == '0)      ? (enable_i ? S_ARB : S_IDLE)
           : S_XFER;
  end
  // first non-empty cache at or above the pointer (wrapping), and its clipped burst length
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = '0;
    for (int i = 0; i < TOTAL_NUM; i++) begin
      w_k = {1'b0, r_ptr} + (IDX_W+1)'(i);
      w_k = (w_k >= (IDX_W+1)'(TOTAL_NUM)) ? w_k - (IDX_W+1)'(TOTAL_NUM) : w_k;
      if (!w_found && !cache_empty_i[w_k[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_k[IDX_W-1:0];
      end
    end
    w_cnt = cache_count_i[w_win*CNT_W +: CNT_W];
    w_len = (w_cnt == '0) ? BL_W'(1)
          : (w_cnt > CNT_W'(BURST_MAX)) ? BL_W'(BURST_MAX) : w_cnt[BL_W-1:0];
  end
  // outputs: pop only the granted cache, and only when the output slot is free
  always_comb begin
    w_pop = (r_state == S_XFER) && (r_left != '0) && !cache_empty_i[r_idx] && (!r_valid || m_ready_i);
    cache_rd_en_o = w_pop ? (TOTAL_NUM'(1) << r_idx) : '0;
    busy_o = (r_state != S_IDLE) || r_valid;
  end
  // grant bookkeeping: latch winner and length, count beats, move pointer past the served cache
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_first <= 1'b0;
    end else begin
      if (r_state == S_ARB && w_found) begin
        r_idx   <= w_win;
        r_left  <= w_len;
        r_first <= 1'b1;
      end
      if (w_pop) begin
        r_left  <= r_left - BL_W'(1);
        r_first <= 1'b0;
      end
      if (r_state == S_XFER && r_left == '0)
        r_ptr <= (r_idx == IDX_W'(TOTAL_NUM - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end
  // output stage: load on pop, drop valid once accepted, hold everything while stalled
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_chan  <= '0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_sop   <= r_first;
      r_eop   <= (r_left == BL_W'(1));
      r_chan  <= r_idx;
      r_data  <= cache_dout_i[r_idx*DATA_W +: DATA_W];
    end else if (r_valid && m_ready_i) begin
      r_valid <= 1'b0;
    end
  end
  assign m_valid_o = r_valid;
  assign m_sop_o   = r_sop;
  assign m_eop_o   = r_eop;
  assign m_chan_o  = r_chan;
  assign m_data_o  = r_data;
endmodule

// File: tb/tb_us_timming_rr_scheduler.sv
// tb_us_timming_rr_scheduler: cache model plus beat scoreboard for the round-robin scheduler
module tb_us_timming_rr_scheduler;
  localparam int N = 104, DW = 128, CW = 12, IW = 7;
  logic clk = 1'b0;
  logic rst_i, enable_i, m_ready_i;
  logic [N-1:0] cache_empty_i, cache_rd_en_o;
  logic [N*CW-1:0] cache_count_i;
  logic [N*DW-1:0] cache_dout_i;
  logic m_valid_o, m_sop_o, m_eop_o, busy_o;
  logic [DW-1:0] m_data_o;
  logic [IW-1:0] m_chan_o;
  always #5 clk = ~clk;
  us_timming_rr_scheduler dut (
    .sys_clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .cache_empty_i(cache_empty_i), .cache_count_i(cache_count_i), .cache_dout_i(cache_dout_i),
    .cache_rd_en_o(cache_rd_en_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_sop_o(m_sop_o), .m_eop_o(m_eop_o), .m_chan_o(m_chan_o),
    .busy_o(busy_o)
  );
  typedef struct {logic [DW-1:0] d; int ch; bit sop; bit eop;} beat_t;
  typedef struct {int n_ch; int ch[3]; int cnt[3]; bit zc; bit rnd; int nb; int bch[6]; int blen[6];} vec_t;
  beat_t q[$];
  vec_t  v[5];
  int cnt[N], head[N];
  bit zc[N];
  int n_tests = 0, n_fail = 0;
  function automatic logic [DW-1:0] dgen(int k, int n);
    return {32'(k), 32'(n), 32'hC0DE0000 | 32'(k), 32'(n * 7 + k + 1)};
  endfunction
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      cache_empty_i[k] = (cnt[k] == 0);
      cache_count_i[k*CW +: CW] = zc[k] ? '0 : CW'(cnt[k]);
      cache_dout_i[k*DW +: DW] = dgen(k, head[k]);
    end
  endtask
  task automatic push_burst(int k, int len, int s);
    for (int b = 0; b < len; b++) q.push_back('{dgen(k, s + b), k, b == 0, b == len - 1});
  endtask
  task automatic tick(output logic [N-1:0] rd);
    logic pv, pr, ps, pe;
    logic [DW-1:0] pd;
    logic [IW-1:0] pc;
    beat_t e;
    @(negedge clk);
    rd = cache_rd_en_o;
    pv = m_valid_o; pr = m_ready_i; ps = m_sop_o; pe = m_eop_o; pc = m_chan_o; pd = m_data_o;
    chk("rd_en_legal", ($onehot0(rd) && ((rd & cache_empty_i) == '0)), 1);
    if (pv && pr) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got chan %0d data %0h, expected no beat", pc, pd);
      end else begin
        e = q.pop_front();
        chk("beat_data", pd, e.d);
        chk("beat_chan", pc, e.ch);
        chk("beat_sop", ps, e.sop);
        chk("beat_eop", pe, e.eop);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (rd[k] && cnt[k] > 0) begin cnt[k]--; head[k]++; end
    drive();
    if (pv && !pr && !rst_i) begin
      chk("hold_data", m_data_o, pd);
      chk("hold_ctl", {m_valid_o, m_sop_o, m_eop_o, m_chan_o}, {1'b1, ps, pe, pc});
    end
  endtask
  task automatic drain(string name, bit rnd);
    logic [N-1:0] rd;
    int s;
    for (int c = 0; c < 3000; c++) begin
      m_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(rd);
      if (q.size() == 0 && !busy_o) break;
    end
    m_ready_i = 1'b1;
    chk({name, "_drain"}, q.size(), 0);
    chk({name, "_busy"}, busy_o, 0);
    s = 0;
    for (int k = 0; k < N; k++) s += cnt[k];
    chk({name, "_left"}, s, 0);
  endtask
  initial begin
    logic [N-1:0] rd;
    int nxt[N];
    v[0] = '{2, '{2, 90, 0},    '{20, 20, 0}, 1'b0, 1'b0, 4, '{2, 90, 2, 90, 0, 0}, '{16, 16, 4, 4, 0, 0}};
    v[1] = '{1, '{5, 0, 0},     '{3, 0, 0},   1'b0, 1'b0, 1, '{5, 0, 0, 0, 0, 0},   '{3, 0, 0, 0, 0, 0}};
    v[2] = '{1, '{7, 0, 0},     '{40, 0, 0},  1'b0, 1'b0, 3, '{7, 7, 7, 0, 0, 0},   '{16, 16, 8, 0, 0, 0}};
    v[3] = '{3, '{102, 103, 0}, '{1, 2, 2},   1'b0, 1'b1, 3, '{102, 103, 0, 0, 0, 0}, '{1, 2, 2, 0, 0, 0}};
    v[4] = '{1, '{50, 0, 0},    '{2, 0, 0},   1'b1, 1'b1, 2, '{50, 50, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0}};
    for (int k = 0; k < N; k++) begin cnt[k] = 0; head[k] = 0; zc[k] = 1'b0; end
    rst_i = 1'b1; enable_i = 1'b1; m_ready_i = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_rd_en", cache_rd_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_ctl", {m_sop_o, m_eop_o, m_chan_o}, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) begin zc[k] = 1'b0; nxt[k] = head[k]; end
      for (int c = 0; c < v[i].n_ch; c++) begin
        cnt[v[i].ch[c]] = v[i].cnt[c];
        zc[v[i].ch[c]] = v[i].zc;
      end
      for (int b = 0; b < v[i].nb; b++) begin
        push_burst(v[i].bch[b], v[i].blen[b], nxt[v[i].bch[b]]);
        nxt[v[i].bch[b]] += v[i].blen[b];
      end
      drive();
      drain($sformatf("vec%0d", i), v[i].rnd);
    end
    for (int k = 0; k < N; k++) zc[k] = 1'b0;
    cnt[10] = 4;
    push_burst(10, 4, head[10]);
    drive();
    for (int c = 0; c < 100; c++) begin
      tick(rd);
      if (m_valid_o && !m_sop_o) break;
    end
    chk("bp_beat1_seen", {m_valid_o, m_sop_o}, 2'b10);
    m_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(rd);
      chk("bp_no_rd", rd, 0);
    end
    drain("bp", 1'b0);
    cnt[20] = 10;
    push_burst(20, 10, head[20]);
    drive();
    for (int c = 0; c < 100; c++) begin
      tick(rd);
      if (q.size() == 8 && m_valid_o) break;
    end
    chk("mid_beat2_seen", q.size(), 8);
    rst_i = 1'b1;
    cnt[3] = 2;
    drive();
    tick(rd);
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_rd_en", cache_rd_en_o, 0);
    chk("mid_rst_ctl", {m_sop_o, m_eop_o, m_chan_o, busy_o}, 0);
    chk("mid_rst_data", m_data_o, 0);
    q.delete();
    push_burst(3, 2, head[3]);
    push_burst(20, cnt[20], head[20]);
    rst_i = 1'b0;
    drain("after_rst", 1'b0);
    enable_i = 1'b0;
    cnt[60] = 2;
    drive();
    for (int c = 0; c < 10; c++) tick(rd);
    chk("disabled_idle", {busy_o, cnt[60] == 2}, 2'b01);
    push_burst(60, 2, head[60]);
    enable_i = 1'b1;
    drain("enable", 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
